// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32I instruction FIFO with a registered decode stage between fetch and dispatch.
module decode_queue #(
   parameter int QUEUE_ADDR_W = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    flush_in,
   input  logic                    fetch_valid_in,
   input  logic [31:0]             fetch_inst_in,
   input  logic [31:0]             fetch_pc_in,
   input  logic                    fetch_pred_in,
   output logic                    fetch_ready_out,
   output logic                    dec_valid_out,
   input  logic                    dec_ready_in,
   output logic [31:0]             dec_pc_out,
   output logic                    dec_pred_out,
   output logic [4:0]              dec_rd_out,
   output logic [4:0]              dec_rs1_out,
   output logic [4:0]              dec_rs2_out,
   output logic [31:0]             dec_imm_out,
   output logic [5:0]              dec_code_out,
   output logic [2:0]              dec_type_out,
   output logic                    dec_rs1_en_out,
   output logic                    dec_rs2_en_out,
   output logic                    dec_rd_en_out,
   output logic                    dec_illegal_out,
   output logic [QUEUE_ADDR_W:0]   count_out
);

   localparam int DEPTH = 1 << QUEUE_ADDR_W;
   localparam logic [QUEUE_ADDR_W:0] DEPTH_C = (QUEUE_ADDR_W + 1)'(DEPTH);

   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

   localparam logic [2:0] T_ALU = 3'd1, T_LD = 3'd2, T_ST = 3'd3, T_BRC = 3'd4, T_JMP = 3'd5;

   localparam logic [5:0] C_LUI = 6'd1, C_AUIPC = 6'd2, C_JAL = 6'd3, C_JALR = 6'd4,
                          C_BEQ = 6'd5, C_BNE = 6'd6, C_BLT = 6'd7, C_BGE = 6'd8,
                          C_BLTU = 6'd9, C_BGEU = 6'd10, C_LB = 6'd11, C_LH = 6'd12,
                          C_LW = 6'd13, C_LBU = 6'd14, C_LHU = 6'd15, C_SB = 6'd16,
                          C_SH = 6'd17, C_SW = 6'd18, C_ADDI = 6'd19, C_SLTI = 6'd20,
                          C_SLTIU = 6'd21, C_XORI = 6'd22, C_ORI = 6'd23, C_ANDI = 6'd24,
                          C_SLLI = 6'd25, C_SRLI = 6'd26, C_SRAI = 6'd27, C_ADD = 6'd28,
                          C_SUB = 6'd29, C_SLL = 6'd30, C_SLT = 6'd31, C_SLTU = 6'd32,
                          C_XOR = 6'd33, C_SRL = 6'd34, C_SRA = 6'd35, C_OR = 6'd36,
                          C_AND = 6'd37;

   logic [31:0]             r_inst_mem [DEPTH];
   logic [31:0]             r_pc_mem   [DEPTH];
   logic                    r_pred_mem [DEPTH];
   logic [QUEUE_ADDR_W-1:0] r_wptr, r_rptr;
   logic [QUEUE_ADDR_W:0]   r_count;

   logic        r_valid, r_pred, r_rs1_en, r_rs2_en, r_rd_en, r_illegal;
   logic [31:0] r_pc, r_imm;
   logic [4:0]  r_rd, r_rs1, r_rs2;
   logic [5:0]  r_code;
   logic [2:0]  r_type;

   logic        w_push, w_pop, w_full, w_empty;
   logic [31:0] w_inst;
   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   logic [5:0]  w_code;
   logic [2:0]  w_type;
   logic [31:0] w_imm;
   logic        w_rs1_en, w_rs2_en, w_rd_wr, w_ill;

   assign w_full          = (r_count == DEPTH_C);
   assign w_empty         = (r_count == '0);
   assign fetch_ready_out = !w_full;
   assign w_push          = fetch_valid_in && !w_full;
   assign w_pop           = !w_empty && (!r_valid || dec_ready_in);

   assign w_inst   = r_inst_mem[r_rptr];
   assign w_opcode = w_inst[6:0];
   assign w_f3     = w_inst[14:12];
   assign w_f7     = w_inst[31:25];
   assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
   assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
   assign w_imm_b  = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
   assign w_imm_u  = {w_inst[31:12], 12'b0};
   assign w_imm_j  = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

   // Decode of the FIFO head; an illegal word collapses to all-zero decode fields.
   always_comb begin
      w_code   = '0;
      w_type   = '0;
      w_imm    = '0;
      w_rs1_en = 1'b0;
      w_rs2_en = 1'b0;
      w_rd_wr  = 1'b0;
      w_ill    = 1'b0;
      case (w_opcode)
         OP_LUI: begin
            w_code = C_LUI; w_type = T_ALU; w_imm = w_imm_u; w_rd_wr = 1'b1;
         end
         OP_AUIPC: begin
            w_code = C_AUIPC; w_type = T_ALU; w_imm = w_imm_u; w_rd_wr = 1'b1;
         end
         OP_JAL: begin
            w_code = C_JAL; w_type = T_JMP; w_imm = w_imm_j; w_rd_wr = 1'b1;
         end
         OP_JALR: begin
            w_code = C_JALR; w_type = T_JMP; w_imm = w_imm_i; w_rs1_en = 1'b1; w_rd_wr = 1'b1;
            w_ill  = (w_f3 != 3'b000);
         end
         OP_BRANCH: begin
            w_type = T_BRC; w_imm = w_imm_b; w_rs1_en = 1'b1; w_rs2_en = 1'b1;
            case (w_f3)
               3'b000:  w_code = C_BEQ;
               3'b001:  w_code = C_BNE;
               3'b100:  w_code = C_BLT;
               3'b101:  w_code = C_BGE;
               3'b110:  w_code = C_BLTU;
               3'b111:  w_code = C_BGEU;
               default: w_ill  = 1'b1;
            endcase
         end
         OP_LOAD: begin
            w_type = T_LD; w_imm = w_imm_i; w_rs1_en = 1'b1; w_rd_wr = 1'b1;
            case (w_f3)
               3'b000:  w_code = C_LB;
               3'b001:  w_code = C_LH;
               3'b010:  w_code = C_LW;
               3'b100:  w_code = C_LBU;
               3'b101:  w_code = C_LHU;
               default: w_ill  = 1'b1;
            endcase
         end
         OP_STORE: begin
            w_type = T_ST; w_imm = w_imm_s; w_rs1_en = 1'b1; w_rs2_en = 1'b1;
            case (w_f3)
               3'b000:  w_code = C_SB;
               3'b001:  w_code = C_SH;
               3'b010:  w_code = C_SW;
               default: w_ill  = 1'b1;
            endcase
         end
         OP_IMM: begin
            w_type = T_ALU; w_imm = w_imm_i; w_rs1_en = 1'b1; w_rd_wr = 1'b1;
            case (w_f3)
               3'b000: w_code = C_ADDI;
               3'b010: w_code = C_SLTI;
               3'b011: w_code = C_SLTIU;
               3'b100: w_code = C_XORI;
               3'b110: w_code = C_ORI;
               3'b111: w_code = C_ANDI;
               3'b001: begin
                  w_code = C_SLLI; w_imm = {27'b0, w_inst[24:20]};
                  w_ill  = (w_f7 != 7'h00);
               end
               default: begin
                  w_code = (w_f7 == 7'h20) ? C_SRAI : C_SRLI;
                  w_imm  = {27'b0, w_inst[24:20]};
                  w_ill  = (w_f7 != 7'h00) && (w_f7 != 7'h20);
               end
            endcase
         end
         OP_REG: begin
            w_type = T_ALU; w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_rd_wr = 1'b1;
            if (w_f7 == 7'h20) begin
               case (w_f3)
                  3'b000:  w_code = C_SUB;
                  3'b101:  w_code = C_SRA;
                  default: w_ill  = 1'b1;
               endcase
            end else begin
               w_ill = (w_f7 != 7'h00);
               case (w_f3)
                  3'b000:  w_code = C_ADD;
                  3'b001:  w_code = C_SLL;
                  3'b010:  w_code = C_SLT;
                  3'b011:  w_code = C_SLTU;
                  3'b100:  w_code = C_XOR;
                  3'b101:  w_code = C_SRL;
                  3'b110:  w_code = C_OR;
                  default: w_code = C_AND;
               endcase
            end
         end
         default: w_ill = 1'b1;
      endcase
      if (w_ill) begin
         w_code   = '0;
         w_type   = '0;
         w_imm    = '0;
         w_rs1_en = 1'b0;
         w_rs2_en = 1'b0;
         w_rd_wr  = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && !flush_in && w_push) begin
         r_inst_mem[r_wptr] <= fetch_inst_in;
         r_pc_mem[r_wptr]   <= fetch_pc_in;
         r_pred_mem[r_wptr] <= fetch_pred_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_pred    <= 1'b0;
         r_rd      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_imm     <= '0;
         r_code    <= '0;
         r_type    <= '0;
         r_rs1_en  <= 1'b0;
         r_rs2_en  <= 1'b0;
         r_rd_en   <= 1'b0;
         r_illegal <= 1'b0;
      end else if (rdy_in) begin
         if (flush_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_pop) begin
               r_valid   <= 1'b1;
               r_pc      <= r_pc_mem[r_rptr];
               r_pred    <= r_pred_mem[r_rptr];
               r_rd      <= w_inst[11:7];
               r_rs1     <= w_inst[19:15];
               r_rs2     <= w_inst[24:20];
               r_imm     <= w_imm;
               r_code    <= w_code;
               r_type    <= w_type;
               r_rs1_en  <= w_rs1_en;
               r_rs2_en  <= w_rs2_en;
               r_rd_en   <= w_rd_wr && (w_inst[11:7] != 5'd0);
               r_illegal <= w_ill;
            end else if (dec_ready_in) begin
               r_valid <= 1'b0;
            end
         end
      end
   end

   assign dec_valid_out   = r_valid;
   assign dec_pc_out      = r_pc;
   assign dec_pred_out    = r_pred;
   assign dec_rd_out      = r_rd;
   assign dec_rs1_out     = r_rs1;
   assign dec_rs2_out     = r_rs2;
   assign dec_imm_out     = r_imm;
   assign dec_code_out    = r_code;
   assign dec_type_out    = r_type;
   assign dec_rs1_en_out  = r_rs1_en;
   assign dec_rs2_en_out  = r_rs2_en;
   assign dec_rd_en_out   = r_rd_en;
   assign dec_illegal_out = r_illegal;
   assign count_out       = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue.
module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        fetch_valid, fetch_pred, fetch_ready;
   logic [31:0] fetch_inst, fetch_pc;
   logic        dec_valid, dec_ready, dec_pred;
   logic [31:0] dec_pc, dec_imm;
   logic [4:0]  dec_rd, dec_rs1, dec_rs2;
   logic [5:0]  dec_code;
   logic [2:0]  dec_type;
   logic        dec_rs1_en, dec_rs2_en, dec_rd_en, dec_illegal;
   logic [4:0]  count;

   int n_cmp = 0;
   int n_err = 0;
   int nxt;
   int exp_idx;

   always #5 clk = ~clk;

   decode_queue #(.QUEUE_ADDR_W(4)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
      .fetch_valid_in(fetch_valid), .fetch_inst_in(fetch_inst), .fetch_pc_in(fetch_pc),
      .fetch_pred_in(fetch_pred), .fetch_ready_out(fetch_ready),
      .dec_valid_out(dec_valid), .dec_ready_in(dec_ready), .dec_pc_out(dec_pc),
      .dec_pred_out(dec_pred), .dec_rd_out(dec_rd), .dec_rs1_out(dec_rs1), .dec_rs2_out(dec_rs2),
      .dec_imm_out(dec_imm), .dec_code_out(dec_code), .dec_type_out(dec_type),
      .dec_rs1_en_out(dec_rs1_en), .dec_rs2_en_out(dec_rs2_en), .dec_rd_en_out(dec_rd_en),
      .dec_illegal_out(dec_illegal), .count_out(count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addi_w(input int k);
      return 32'h00000113 | (32'(k) << 20);
   endfunction

   // Push one word into an empty queue, then wait until it is held on dec_*.
   task automatic push_and_hold(input logic [31:0] inst, input logic [31:0] pc);
      fetch_valid = 1'b1;
      fetch_inst  = inst;
      fetch_pc    = pc;
      step();
      fetch_valid = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      fetch_valid = 1'b0; fetch_inst = '0; fetch_pc = '0; fetch_pred = 1'b0;
      dec_ready = 1'b0;
      step();
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_pc", dec_pc, 32'd0);
      chk("rst_code", 32'(dec_code), 32'd0);
      chk("rst_ready", 32'(fetch_ready), 32'd1);
      rst = 1'b0;

      // ADDI x1,x0,5 with one-cycle decode latency
      fetch_valid = 1'b1; fetch_inst = 32'h00500093; fetch_pc = 32'h0; fetch_pred = 1'b1;
      step();
      chk("t1_lat_valid", 32'(dec_valid), 32'd0);
      chk("t1_lat_count", 32'(count), 32'd1);
      fetch_valid = 1'b0; fetch_pred = 1'b0;
      step();
      chk("t1_valid", 32'(dec_valid), 32'd1);
      chk("t1_code", 32'(dec_code), 32'd19);
      chk("t1_type", 32'(dec_type), 32'd1);
      chk("t1_imm", dec_imm, 32'd5);
      chk("t1_rd", 32'(dec_rd), 32'd1);
      chk("t1_rd_en", 32'(dec_rd_en), 32'd1);
      chk("t1_rs1_en", 32'(dec_rs1_en), 32'd1);
      chk("t1_rs2_en", 32'(dec_rs2_en), 32'd0);
      chk("t1_pred", 32'(dec_pred), 32'd1);
      chk("t1_count", 32'(count), 32'd0);
      dec_ready = 1'b1;
      step();
      chk("t1_consumed", 32'(dec_valid), 32'd0);

      // Fill: 1 held + 16 queued, then an offer against a full queue
      dec_ready = 1'b0; fetch_valid = 1'b1; nxt = 0;
      repeat (17) begin
         fetch_inst = addi_w(nxt); fetch_pc = 32'h100 + 32'(4 * nxt);
         step();
         nxt++;
      end
      chk("t2_count_full", 32'(count), 32'd16);
      chk("t2_ready_full", 32'(fetch_ready), 32'd0);
      chk("t2_head_pc", dec_pc, 32'h100);
      fetch_inst = addi_w(nxt); fetch_pc = 32'h100 + 32'(4 * nxt);
      step();
      chk("t2_17th_count", 32'(count), 32'd16);
      chk("t2_hold_pc", dec_pc, 32'h100);

      // Full queue with pop: push refused, count drops to 15
      dec_ready = 1'b1;
      step();
      chk("t3_count_15", 32'(count), 32'd15);
      chk("t3_pc_w1", dec_pc, 32'h104);
      exp_idx = 2;
      repeat (4) begin
         fetch_inst = addi_w(nxt); fetch_pc = 32'h100 + 32'(4 * nxt);
         step();
         nxt++;
         chk("t3_stream_count", 32'(count), 32'd15);
         chk("t3_stream_pc", dec_pc, 32'h100 + 32'(4 * exp_idx));
         exp_idx++;
      end
      fetch_valid = 1'b0;
      while (exp_idx <= 20) begin
         step();
         chk("t3_drain_pc", dec_pc, 32'h100 + 32'(4 * exp_idx));
         chk("t3_drain_imm", dec_imm, 32'(exp_idx));
         exp_idx++;
      end
      step();
      chk("t3_empty_valid", 32'(dec_valid), 32'd0);
      chk("t3_empty_count", 32'(count), 32'd0);

      // Flush with 5 queued + 1 held and a fetch offered
      dec_ready = 1'b0; fetch_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         fetch_inst = addi_w(k); fetch_pc = 32'h300 + 32'(4 * k);
         step();
      end
      chk("t4_pre_count", 32'(count), 32'd5);
      chk("t4_pre_pc", dec_pc, 32'h300);
      flush = 1'b1; fetch_inst = addi_w(9); fetch_pc = 32'h400;
      step();
      flush = 1'b0;
      chk("t4_flush_count", 32'(count), 32'd0);
      chk("t4_flush_valid", 32'(dec_valid), 32'd0);
      fetch_inst = addi_w(7); fetch_pc = 32'h500;
      step();
      chk("t4_post_count", 32'(count), 32'd1);
      fetch_valid = 1'b0;
      step();
      chk("t4_post_valid", 32'(dec_valid), 32'd1);
      chk("t4_post_pc", dec_pc, 32'h500);
      chk("t4_post_imm", dec_imm, 32'd7);
      chk("t4_post_count0", 32'(count), 32'd0);

      // Decode corner cases
      dec_ready = 1'b1;
      push_and_hold(32'h00002067, 32'h200);
      chk("t5_jalr_ill", 32'(dec_illegal), 32'd1);
      chk("t5_jalr_code", 32'(dec_code), 32'd0);
      chk("t5_jalr_type", 32'(dec_type), 32'd0);
      chk("t5_jalr_rs1en", 32'(dec_rs1_en), 32'd0);
      chk("t5_jalr_pc", dec_pc, 32'h200);
      push_and_hold(32'h40105093, 32'h204);
      chk("t5_srai_code", 32'(dec_code), 32'd27);
      chk("t5_srai_imm", dec_imm, 32'd1);
      chk("t5_srai_ill", 32'(dec_illegal), 32'd0);
      chk("t5_srai_rd_en", 32'(dec_rd_en), 32'd1);
      push_and_hold(32'h123450B7, 32'h208);
      chk("t5_lui_code", 32'(dec_code), 32'd1);
      chk("t5_lui_imm", dec_imm, 32'h12345000);
      chk("t5_lui_rs1en", 32'(dec_rs1_en), 32'd0);
      push_and_hold(32'hFE20AE23, 32'h20C);
      chk("t5_sw_code", 32'(dec_code), 32'd18);
      chk("t5_sw_type", 32'(dec_type), 32'd3);
      chk("t5_sw_imm", dec_imm, 32'hFFFFFFFC);
      chk("t5_sw_rs2en", 32'(dec_rs2_en), 32'd1);
      chk("t5_sw_rd_en", 32'(dec_rd_en), 32'd0);
      push_and_hold(32'h402081B3, 32'h210);
      chk("t5_sub_code", 32'(dec_code), 32'd29);
      chk("t5_sub_rs2en", 32'(dec_rs2_en), 32'd1);
      push_and_hold(32'h402091B3, 32'h214);
      chk("t5_r_f7_ill", 32'(dec_illegal), 32'd1);
      chk("t5_r_f7_rden", 32'(dec_rd_en), 32'd0);
      push_and_hold(32'h00000013, 32'h218);
      chk("t5_nop_rd_en", 32'(dec_rd_en), 32'd0);
      chk("t5_nop_code", 32'(dec_code), 32'd19);

      // rdy_in low freezes everything
      step();
      dec_ready = 1'b0; fetch_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fetch_inst = addi_w(k); fetch_pc = 32'h600 + 32'(4 * k);
         step();
      end
      chk("t6_pre_count", 32'(count), 32'd2);
      rdy = 1'b0; dec_ready = 1'b1; fetch_inst = addi_w(3); fetch_pc = 32'h60C;
      repeat (3) step();
      chk("t6_frz_count", 32'(count), 32'd2);
      chk("t6_frz_pc", dec_pc, 32'h600);
      chk("t6_frz_valid", 32'(dec_valid), 32'd1);
      rdy = 1'b1;
      step();
      chk("t6_res_count", 32'(count), 32'd2);
      chk("t6_res_pc", dec_pc, 32'h604);
      fetch_valid = 1'b0;
      step();
      chk("t6_res2_count", 32'(count), 32'd1);
      chk("t6_res2_pc", dec_pc, 32'h608);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
